// File: rtl/seg7_scan_if.sv
// Digit write / commit port and scan outputs of the 7-segment scan controller.
// The controller binds the slave modport; the host or bench binds master.
interface seg7_scan_if #(
  parameter int NDIGIT = 4,
  parameter int AW     = 2
);

  logic              we;
  logic [AW-1:0]     waddr;
  logic [3:0]        wdata;
  logic              commit;
  logic [3:0]        hex;
  logic [NDIGIT-1:0] digit_en;
  logic              blank;
  logic              frame;
  logic              pending;

  modport master (
    output we, waddr, wdata, commit,
    input  hex, digit_en, blank, frame, pending
  );

  modport slave (
    input  we, waddr, wdata, commit,
    output hex, digit_en, blank, frame, pending
  );

endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a shadow/active digit bank.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
`default_nettype none

module seg7_scan_ctrl #(
  parameter int NDIGIT   = 4,
  parameter int AW       = 2,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NDIGIT);

  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic [3:0]    shadow [NDIGIT];
  logic [3:0]    active [NDIGIT];
  logic          frame_q;
  logic          pending_q;
  logic          tick;
  logic          wrap;
  logic          suppress;

  assign tick = (pcnt == PW'(PRESCALE - 1));
  assign wrap = tick && (idx == IW'(NDIGIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= (idx == IW'(NDIGIT - 1)) ? '0 : idx + IW'(1);
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // The copy reads shadow before this edge's write, so a write colliding
  // with the copy is left pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIGIT; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= wrap;
      for (int i = 0; i < NDIGIT; i++) begin
        if (bus.we && (bus.waddr == AW'(i))) begin
          shadow[i] <= bus.wdata;
        end
      end
      if (wrap) begin
        if (pending_q || bus.commit) begin
          for (int i = 0; i < NDIGIT; i++) begin
            active[i] <= shadow[i];
          end
          pending_q <= bus.we;
        end else begin
          pending_q <= 1'b0;
        end
      end else begin
        pending_q <= pending_q | bus.commit;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  // Most significant non-zero digit of the displayed bank; digit 0 always lit.
  always_comb begin
    msd = '0;
    for (int i = 1; i < NDIGIT; i++) begin
      if (active[i] != 4'd0) begin
        msd = IW'(i);
      end
    end
  end

  assign suppress = (idx > msd);
`else
  assign suppress = 1'b0;
`endif

  assign bus.hex      = active[idx];
  assign bus.blank    = (pcnt < PW'(GUARD)) || suppress;
  assign bus.digit_en = bus.blank ? '0 : (NDIGIT'(1) << idx);
  assign bus.frame    = frame_q;
  assign bus.pending  = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: cycle-count reference model,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps

module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int P  = 4;
  localparam int G  = 1;
  localparam int FL = N * P;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   checkEn;

  seg7_scan_if #(.NDIGIT(N), .AW(AW)) bus ();

  seg7_scan_ctrl #(
    .NDIGIT  (N),
    .AW      (AW),
    .PRESCALE(P),
    .GUARD   (G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position in the scan is derived from the cycle count
  // since reset; banks and the pending flag follow the commit rules.
  int         mt;
  logic [3:0] msh [N];
  logic [3:0] mac [N];
  logic       mpend;
  logic       mframe;

  always @(posedge clk or posedge rst) begin : model
    bit wrapNow;
    if (rst) begin
      mt = 0;
      for (int i = 0; i < N; i++) begin
        msh[i] = 4'd0;
        mac[i] = 4'd0;
      end
      mpend  = 1'b0;
      mframe = 1'b0;
    end else begin
      wrapNow = ((mt % FL) == FL - 1);
      if (wrapNow) begin
        if (mpend || bus.commit) begin
          for (int i = 0; i < N; i++) mac[i] = msh[i];
          mpend = bus.we;
        end else begin
          mpend = 1'b0;
        end
      end else if (bus.commit) begin
        mpend = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.we && (int'(bus.waddr) == i)) msh[i] = bus.wdata;
      end
      mframe = wrapNow;
      mt     = mt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int         pc;
    int         id;
    int         msd;
    bit         sup;
    logic       eBlank;
    logic [N-1:0] eEn;
    logic [3:0] eHex;
    if (checkEn) begin
      pc  = mt % P;
      id  = (mt / P) % N;
      msd = 0;
      for (int i = 1; i < N; i++) if (mac[i] != 4'd0) msd = i;
`ifdef LEADING_ZERO_BLANK_EN
      sup = (id > msd);
`else
      sup = 1'b0;
`endif
      eBlank = (pc < G) || sup;
      eEn    = eBlank ? '0 : N'(1 << id);
      eHex   = 4'd0;
      for (int i = 0; i < N; i++) if (i == id) eHex = mac[i];
      checkOutput("hex",      32'(bus.hex),      32'(eHex));
      checkOutput("digit_en", 32'(bus.digit_en), 32'(eEn));
      checkOutput("blank",    32'(bus.blank),    32'(eBlank));
      checkOutput("frame",    32'(bus.frame),    32'(mframe));
      checkOutput("pending",  32'(bus.pending),  32'(mpend));
    end
  end

  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [3:0] data, input logic commit);
    bus.we     = we;
    bus.waddr  = addr;
    bus.wdata  = data;
    bus.commit = commit;
    @(negedge clk);
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = 4'd0;
    bus.commit = 1'b0;
  endtask

  task automatic waitPhase(input int ph);
    int n;
    n = 0;
    while (((mt % FL) != ph) && (n < 3 * FL)) begin
      @(negedge clk);
      n++;
    end
    if ((mt % FL) != ph) checkOutput("waitPhase", 32'(mt % FL), 32'(ph));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    checkEn    = 1'b0;
    rst        = 1'b1;
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = 4'd0;
    bus.commit = 1'b0;
    @(negedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Idle scan after reset
    checkOutput("lit_en_guard", 32'(bus.digit_en), 32'h0);
    checkOutput("lit_blank_guard", 32'(bus.blank), 32'h1);
    checkOutput("lit_hex_idle", 32'(bus.hex), 32'h0);
    @(negedge clk);
    checkOutput("lit_en_d0", 32'(bus.digit_en), 32'b0001);
    repeat (4) @(negedge clk);
    checkOutput("lit_en_d1", 32'(bus.digit_en), 32'b0010);
    repeat (11) @(negedge clk);
    checkOutput("lit_frame16", 32'(bus.frame), 32'h1);

    // Fill shadow 1..4 and commit mid-frame
    waitPhase(2);
    for (int i = 0; i < N; i++) applyStimulus(1'b1, AW'(i), 4'(i + 1), 1'b0);
    applyStimulus(1'b0, '0, 4'd0, 1'b1);
    checkOutput("lit_pending_set", 32'(bus.pending), 32'h1);
    checkOutput("lit_hex_old", 32'(bus.hex), 32'h0);
    waitPhase(0);
    checkOutput("lit_hex_new_d0", 32'(bus.hex), 32'h1);
    checkOutput("lit_pending_clr", 32'(bus.pending), 32'h0);
    waitPhase(4);
    checkOutput("lit_hex_new_d1", 32'(bus.hex), 32'h2);

    // Out-of-range write with commit leaves the display unchanged
    waitPhase(6);
    applyStimulus(1'b1, AW'(5), 4'd7, 1'b1);
    waitPhase(0);
    checkOutput("lit_oor_d0", 32'(bus.hex), 32'h1);
    waitPhase(12);
    checkOutput("lit_oor_d3", 32'(bus.hex), 32'h4);

    // Write colliding with the commit copy at the wrap
    waitPhase(5);
    applyStimulus(1'b0, '0, 4'd0, 1'b1);
    waitPhase(15);
    applyStimulus(1'b1, AW'(2), 4'd9, 1'b0);
    checkOutput("lit_pending_collide", 32'(bus.pending), 32'h1);
    waitPhase(8);
    checkOutput("lit_hex_excl9", 32'(bus.hex), 32'h3);
    waitPhase(0);
    checkOutput("lit_pending_after", 32'(bus.pending), 32'h0);
    waitPhase(8);
    checkOutput("lit_hex_9", 32'(bus.hex), 32'h9);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of slot 2
    waitPhase(10);
    #1 rst = 1'b1;
    #1;
    checkOutput("lit_rst_hex", 32'(bus.hex), 32'h0);
    checkOutput("lit_rst_en", 32'(bus.digit_en), 32'h0);
    checkOutput("lit_rst_blank", 32'(bus.blank), 32'h1);
    checkOutput("lit_rst_pending", 32'(bus.pending), 32'h0);
    checkOutput("lit_rst_frame", 32'(bus.frame), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Only digit 0 non-zero: leading zeros blank when the feature is built in
    applyStimulus(1'b1, AW'(0), 4'd7, 1'b0);
    applyStimulus(1'b0, '0, 4'd0, 1'b1);
    waitPhase(0);
    checkOutput("lit_lz_hex0", 32'(bus.hex), 32'h7);
    waitPhase(6);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("lit_lz_blank1", 32'(bus.blank), 32'h1);
    checkOutput("lit_lz_en1", 32'(bus.digit_en), 32'h0);
`else
    checkOutput("lit_lz_blank1", 32'(bus.blank), 32'h0);
    checkOutput("lit_lz_en1", 32'(bus.digit_en), 32'b0010);
`endif
    waitPhase(14);
    checkOutput("lit_lz_hex3", 32'(bus.hex), 32'h0);

    repeat (5) @(negedge clk);
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
